// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA timing generator.
// Defaults describe 800x600 @ 72 Hz (50 MHz pixel clock).
package vga_timing_pkg;

  localparam int COORD_W   = 12;
  localparam int DIV_W     = 4;
  localparam int MAX_TOTAL = 1 << COORD_W;
  localparam int MAX_DIV   = 1 << DIV_W;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;
  localparam bit DEF_HS_POL   = 1'b1;
  localparam bit DEF_VS_POL   = 1'b1;
  localparam int DEF_CLK_DIV  = 1;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_HS_FIRST = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_LAST  = DEF_HS_FIRST + DEF_H_SYNC - 1;
  localparam int DEF_VS_FIRST = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_LAST  = DEF_VS_FIRST + DEF_V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_wrap_cnt.sv
// Modulo-N counter with enable and synchronous reset to an arbitrary value.
// o_nxt exposes the value the counter takes at the next edge (when not in reset).
module vga_wrap_cnt #(
  parameter int N       = 2,
  parameter int W       = 12,
  parameter int RST_VAL = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST  = W'(N - 1);
  localparam logic [W-1:0] RSTV  = W'(RST_VAL);

  logic [W-1:0] r_cnt;
  logic         w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_wrap    = i_en && w_at_last;
  assign o_cnt     = r_cnt;

  always_comb begin
    o_nxt = r_cnt;
    if (i_en) begin
      o_nxt = w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= RSTV;
    end else begin
      r_cnt <= o_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel coordinates, syncs, blanking and strobes, all registered
// together on the pixel tick so coordinates and syncs never skew.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               h_sync,
  output logic               v_sync,
  output logic               video_on,
  output logic               pix_en,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t H_ACT    = COORD_W'(H_ACTIVE);
  localparam coord_t V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL ||
      H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      CLK_DIV < 1 || CLK_DIV > MAX_DIV) begin : g_bad_cfg
    $error("vga_timing_gen: illegal timing parameters");
  end

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  coord_t           w_x_nxt;
  coord_t           w_y_nxt;
  logic             w_x_wrap;
  logic             w_y_wrap;

  logic r_hs;
  logic r_vs;
  logic r_von;
  logic r_pen;
  logic r_ls;
  logic r_fs;

  // Pixel-rate divider: tick on the last phase; CLK_DIV=1 keeps it at 0 (tick every edge).
  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  vga_wrap_cnt #(
    .N       (H_TOTAL),
    .W       (COORD_W),
    .RST_VAL (H_TOTAL - 1)
  ) u_hcnt (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_tick),
    .o_cnt  (pix_x),
    .o_nxt  (w_x_nxt),
    .o_wrap (w_x_wrap)
  );

  vga_wrap_cnt #(
    .N       (V_TOTAL),
    .W       (COORD_W),
    .RST_VAL (V_TOTAL - 1)
  ) u_vcnt (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_x_wrap),
    .o_cnt  (pix_y),
    .o_nxt  (w_y_nxt),
    .o_wrap (w_y_wrap)
  );

  // Decode from the coordinates being loaded this edge so flags line up with pix_x/pix_y.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_von <= 1'b0;
      r_pen <= 1'b0;
      r_ls  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_pen <= w_tick;
      if (w_tick) begin
        r_hs  <= in_window(w_x_nxt, HS_FIRST, HS_LAST) ? HS_POL : ~HS_POL;
        r_vs  <= in_window(w_y_nxt, VS_FIRST, VS_LAST) ? VS_POL : ~VS_POL;
        r_von <= (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
        r_ls  <= (w_x_nxt == '0);
        r_fs  <= (w_x_nxt == '0) && (w_y_nxt == '0);
      end
    end
  end

  logic w_unused;
  assign w_unused = w_y_wrap;

  assign h_sync      = r_hs;
  assign v_sync      = r_vs;
  assign video_on    = r_von;
  assign pix_en      = r_pen;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset scoreboard bench: three configurations checked every cycle against
// a tick-count model of the raster (position = tick index mod line/frame length).
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    bit hpol; bit vpol; int div;
  } cfg_t;

  localparam cfg_t CA = '{ha:800, hfp:56, hsw:120, hbp:64, va:600, vfp:37, vsw:6, vbp:23,
                          hpol:1'b1, vpol:1'b1, div:1};
  localparam cfg_t CB = '{ha:10, hfp:2, hsw:3, hbp:2, va:6, vfp:2, vsw:2, vbp:3,
                          hpol:1'b0, vpol:1'b0, div:4};
  localparam cfg_t CC = '{ha:12, hfp:3, hsw:4, hbp:5, va:5, vfp:1, vsw:2, vbp:2,
                          hpol:1'b1, vpol:1'b1, div:1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [11:0] ax, ay, bx, by, cx, cy;
  logic ahs, avs, avon, apen, als, afs;
  logic bhs, bvs, bvon, bpen, bls, bfs;
  logic chs, cvs, cvon, cpen, cls, cfs;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst), .pix_x(ax), .pix_y(ay), .h_sync(ahs), .v_sync(avs),
    .video_on(avon), .pix_en(apen), .line_start(als), .frame_start(afs)
  );

  vga_timing_gen #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2),
    .V_BP(3), .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pix_x(bx), .pix_y(by), .h_sync(bhs), .v_sync(bvs),
    .video_on(bvon), .pix_en(bpen), .line_start(bls), .frame_start(bfs)
  );

  vga_timing_gen #(
    .H_ACTIVE(12), .H_FP(3), .H_SYNC(4), .H_BP(5), .V_ACTIVE(5), .V_FP(1), .V_SYNC(2),
    .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1)
  ) u_dut_c (
    .clk(clk), .rst(rst), .pix_x(cx), .pix_y(cy), .h_sync(chs), .v_sync(cvs),
    .video_on(cvon), .pix_en(cpen), .line_start(cls), .frame_start(cfs)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [29:0] qa[$];
  logic [29:0] qb[$];
  logic [29:0] qc[$];
  int ca = 0, cb = 0, cc = 0;

  // c = number of non-reset edges since the last reset edge; tick k lands on edge k*div.
  function automatic logic [29:0] model(input cfg_t g, input int c);
    int ht, vt, n, t, x, y;
    logic hs, vs, von, pen, ls, fs;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    n  = c / g.div;
    if (n == 0) begin
      x = ht - 1; y = vt - 1;
      hs = ~g.hpol; vs = ~g.vpol;
      von = 1'b0; pen = 1'b0; ls = 1'b0; fs = 1'b0;
    end else begin
      t = n - 1;
      x = t % ht;
      y = (t / ht) % vt;
      hs  = (x >= g.ha + g.hfp && x < g.ha + g.hfp + g.hsw) ? g.hpol : ~g.hpol;
      vs  = (y >= g.va + g.vfp && y < g.va + g.vfp + g.vsw) ? g.vpol : ~g.vpol;
      von = (x < g.ha) && (y < g.va);
      pen = (c % g.div) == 0;
      ls  = (x == 0);
      fs  = (x == 0) && (y == 0);
    end
    return {12'(x), 12'(y), hs, vs, von, pen, ls, fs};
  endfunction

  task automatic cmp(input string name, input logic [29:0] exp, input logic [29:0] act);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got x=%0d y=%0d hs/vs/von/en/ls/fs=%b need x=%0d y=%0d hs/vs/von/en/ls/fs=%b",
               name, $time, act[29:18], act[17:6], act[5:0], exp[29:18], exp[17:6], exp[5:0]);
    end
  endtask

  task automatic drive(input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r;
      @(posedge clk);
      ca = r ? 0 : ca + 1;
      cb = r ? 0 : cb + 1;
      cc = r ? 0 : cc + 1;
      qa.push_back(model(CA, ca));
      qb.push_back(model(CB, cb));
      qc.push_back(model(CC, cc));
      #1;
    end
  endtask

  // Monitor: every cycle presents an output tuple, so pop one expectation per DUT per cycle.
  always @(negedge clk) begin
    if (qa.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL a_queue_empty t=%0t got 0 entries need >=1", $time);
    end else cmp("dut_a", qa.pop_front(), {ax, ay, ahs, avs, avon, apen, als, afs});
    if (qb.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL b_queue_empty t=%0t got 0 entries need >=1", $time);
    end else cmp("dut_b", qb.pop_front(), {bx, by, bhs, bvs, bvon, bpen, bls, bfs});
    if (qc.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL c_queue_empty t=%0t got 0 entries need >=1", $time);
    end else cmp("dut_c", qc.pop_front(), {cx, cy, chs, cvs, cvon, cpen, cls, cfs});
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 2200);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, int'($urandom_range(50, 4000)));
      drive(1'b1, int'($urandom_range(1, 3)));
    end
    drive(1'b0, 2000);
    @(negedge clk);
    #1;
    n_checks++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending need 0", qa.size() + qb.size() + qc.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 56, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 120, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 64, horizontal back porch in pixels; H_TOTAL = sum of the four = 1040.
REQ-005 Parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 Parameter V_FP, default 37, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 Parameter V_BP, default 23, vertical back porch in lines; V_TOTAL = 666.
REQ-009 Parameter HS_POL, default 1, asserted level of h_sync.
REQ-010 Parameter VS_POL, default 1, asserted level of v_sync.
REQ-011 Parameter CLK_DIV, default 1, clk cycles per pixel; legal range 1..16.
REQ-012 clk  input  1  system clock; the block's only clock.
REQ-013 rst  input  1  reset, synchronous, active-high.
REQ-014 pix_x  output  12  current horizontal position, 0..H_TOTAL-1, including blanking.
REQ-015 pix_y  output  12  current vertical position, 0..V_TOTAL-1, including blanking.
REQ-016 h_sync  output  1  horizontal sync, level per HS_POL.
REQ-017 v_sync  output  1  vertical sync, level per VS_POL.
REQ-018 video_on  output  1  high when pix_x < H_ACTIVE and pix_y < V_ACTIVE.
REQ-019 pix_en  output  1  one-clk strobe marking the first cycle each new pixel position is presented.
REQ-020 line_start  output  1  high for the clk cycles that present pix_x = 0.
REQ-021 frame_start  output  1  high for the clk cycles that present pix_x = 0 and pix_y = 0.

Function
REQ-022 A divider counter shall run 0..CLK_DIV-1 and wrap; a pixel tick occurs on the edge where it equals CLK_DIV-1. CLK_DIV = 1 gives a tick on every edge.
REQ-023 On each tick, pix_x shall increment. When pix_x = H_TOTAL-1, it wraps to 0 and pix_y increments. When pix_y = V_TOTAL-1, pix_y wraps to 0 in that same edge.
REQ-024 All outputs shall be registers, updated on the tick edge, and mutually consistent with the pix_x/pix_y presented in the same cycle; there is no skew between coordinates and syncs.
REQ-025 h_sync = HS_POL iff H_ACTIVE+H_FP <= pix_x <= H_ACTIVE+H_FP+H_SYNC-1 (default 856..975); otherwise it is the complement.
REQ-026 v_sync = VS_POL iff V_ACTIVE+V_FP <= pix_y <= V_ACTIVE+V_FP+V_SYNC-1 (default 637..642); otherwise it is the complement.
REQ-027 Between ticks, all outputs except pix_en shall hold their values. pix_en is 1 only in the cycle immediately after a tick edge; with CLK_DIV = 1 it is constantly 1 after reset.
REQ-028 Frame period is exactly H_TOTAL*V_TOTAL ticks (default 692640). Line period is exactly H_TOTAL ticks.
REQ-029 Counter widths shall be 12 bits. Elaboration shall fail if H_TOTAL > 4096, V_TOTAL > 4096, any timing parameter is 0, or CLK_DIV is outside 1..16.

Reset
REQ-030 While rst = 1 at an edge, the block shall load: divider 0, pix_x = H_TOTAL-1, pix_y = V_TOTAL-1, h_sync = !HS_POL, v_sync = !VS_POL, video_on = 0, pix_en = 0, line_start = 0, frame_start = 0.
REQ-031 The first tick after rst deasserts shall wrap to (0,0) and assert frame_start, line_start and video_on. With CLK_DIV = 1, this tick is the first edge sampling rst = 0.
REQ-032 Reset asserted mid-line or mid-frame shall take effect at the next edge, regardless of divider phase.

Structure
REQ-033 Package vga_timing_pkg shall hold the default timing constants, the derived H_TOTAL/V_TOTAL and sync-window bounds, and the 12-bit coordinate width.
REQ-034 One sub-module, vga_wrap_cnt, shall be used twice: a parameterised modulo-N counter with enable, synchronous reset-to-value, and a wrap output.

Verification
REQ-035 Defaults, rst held 3 cycles then released -> at the first edge after release: pix_x=0, pix_y=0, video_on=1, frame_start=1, line_start=1, pix_en=1.
REQ-036 Defaults, run one line -> h_sync high exactly for pix_x 856..975 (120 cycles); video_on low from pix_x 800; pix_x wraps 1039->0 with pix_y +1.
REQ-037 Defaults, run two full frames -> v_sync high for exactly 6 lines (637..642); frame_start pulses exactly 692640 clk cycles apart.
REQ-038 CLK_DIV=4 -> every pix_x value held 4 clk cycles; pix_en high 1 of every 4 cycles; line period 4160 clk cycles.
REQ-039 HS_POL=0, VS_POL=0 -> syncs idle high and pulse low over the same windows; both are high during reset.
REQ-040 rst asserted at pix_x=500, pix_y=300 for 1 cycle -> next edge shows pix_x=1039, pix_y=665, all strobes 0; normal sequence then resumes from (0,0).
